rv_decode_unit: RTL and testbench

Parametrised RV32I/RV32E decode stage with an integrated register file, placed between the fetch stage and the execute stage of the core pipeline. It accepts one instruction per cycle over a valid/ready handshake and generates every base-ISA immediate format. It produces the full control bundle (ALU, memory, branch/jump, writeback) and holds its output under back-pressure. Held operands stay coherent with writeback, a same-cycle writeback is forwarded into the read, and a flush input squashes the stage.

---
 rtl/rv_decode_unit.sv | 242 ++++++++++++++++++++++++
 tb/tb_rv_decode_unit.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_decode_unit.sv
// rv_decode_unit: RV32I/RV32E decode stage with integrated register file.
// One instruction per valid/ready handshake; bundle held under back-pressure.
module rv_decode_unit #(
  parameter int NREGS         = 32,
  parameter bit BYPASS        = 1'b1,
  parameter bit RESET_REGFILE = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_rs1_data,
  output logic [31:0] out_rs2_data,
  output logic [4:0]  out_rs1,
  output logic [4:0]  out_rs2,
  output logic [4:0]  out_rd,
  output logic [2:0]  out_funct3,
  output logic [3:0]  out_alu_ctrl,
  output logic [31:0] out_imm,
  output logic        out_alu_src_imm,
  output logic        out_alu_src_pc,
  output logic        out_wr_en,
  output logic        out_mem_read,
  output logic        out_mem_write,
  output logic        out_branch,
  output logic        out_jump,
  output logic        out_illegal,
  input  logic        wb_wr_en,
  input  logic [4:0]  wb_wr_addr,
  input  logic [31:0] wb_wr_data
);

  localparam int AW = $clog2(NREGS);
  localparam logic [5:0] NR = 6'(NREGS);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [3:0]  alu_ctrl;
    logic        alu_src_imm;
    logic        alu_src_pc;
    logic        wr_en;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        jump;
    logic        illegal;
  } dec_t;

  function automatic logic fits(input logic [4:0] a);
    return {1'b0, a} < NR;
  endfunction

  function automatic logic live(input logic [4:0] a);
    return (a != 5'd0) && fits(a);
  endfunction

  logic [31:0] rf [NREGS];
  dec_t        d;
  dec_t        q;
  logic        vld;

  logic [6:0]  op;
  logic [2:0]  f3;
  logic        is_op, is_opi, is_ld, is_jalr, is_st;
  logic        is_br, is_lui, is_auipc, is_jal;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign op       = in_instr[6:0];
  assign f3       = in_instr[14:12];
  assign is_op    = op == 7'b0110011;
  assign is_opi   = op == 7'b0010011;
  assign is_ld    = op == 7'b0000011;
  assign is_jalr  = op == 7'b1100111;
  assign is_st    = op == 7'b0100011;
  assign is_br    = op == 7'b1100011;
  assign is_lui   = op == 7'b0110111;
  assign is_auipc = op == 7'b0010111;
  assign is_jal   = op == 7'b1101111;

  assign imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
  assign imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign imm_b = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                  in_instr[30:25], in_instr[11:8], 1'b0};
  assign imm_u = {in_instr[31:12], 12'b0};
  assign imm_j = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                  in_instr[20], in_instr[30:21], 1'b0};

  logic        u1, u2, ud, known;
  logic        src_imm, src_pc, mrd, mwr, br, jmp;
  logic [31:0] imm;
  logic [3:0]  alu;

  always_comb begin
    u1      = 1'b0;
    u2      = 1'b0;
    ud      = 1'b0;
    known   = 1'b1;
    src_imm = 1'b0;
    src_pc  = 1'b0;
    mrd     = 1'b0;
    mwr     = 1'b0;
    br      = 1'b0;
    jmp     = 1'b0;
    imm     = '0;
    alu     = 4'b0000;
    unique case (1'b1)
      is_op: begin
        u1 = 1'b1; u2 = 1'b1; ud = 1'b1;
        alu = {in_instr[30], f3};
      end
      is_opi: begin
        u1 = 1'b1; ud = 1'b1; src_imm = 1'b1; imm = imm_i;
        alu = {(f3 == 3'b101) && in_instr[30], f3};
      end
      is_ld: begin
        u1 = 1'b1; ud = 1'b1; src_imm = 1'b1; imm = imm_i; mrd = 1'b1;
      end
      is_jalr: begin
        u1 = 1'b1; ud = 1'b1; src_imm = 1'b1; imm = imm_i; jmp = 1'b1;
      end
      is_st: begin
        u1 = 1'b1; u2 = 1'b1; src_imm = 1'b1; imm = imm_s; mwr = 1'b1;
      end
      is_br: begin
        u1 = 1'b1; u2 = 1'b1; imm = imm_b; br = 1'b1; alu = 4'b1000;
      end
      is_lui: begin
        ud = 1'b1; src_imm = 1'b1; imm = imm_u;
      end
      is_auipc: begin
        ud = 1'b1; src_imm = 1'b1; src_pc = 1'b1; imm = imm_u;
      end
      is_jal: begin
        ud = 1'b1; src_imm = 1'b1; src_pc = 1'b1; imm = imm_j; jmp = 1'b1;
      end
      default: known = 1'b0;
    endcase
  end

  // Unused operand slots read as x0 so hold updates never touch them.
  logic [4:0]  rs1_idx, rs2_idx, rd_idx;
  logic        ill;
  logic [31:0] rd1, rd2;

  assign rs1_idx = u1 ? in_instr[19:15] : 5'd0;
  assign rs2_idx = u2 ? in_instr[24:20] : 5'd0;
  assign rd_idx  = ud ? in_instr[11:7]  : 5'd0;
  assign ill     = !known || !fits(rs1_idx) || !fits(rs2_idx) || !fits(rd_idx);

  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (live(rs1_idx)) rd1 = rf[rs1_idx[AW-1:0]];
    if (live(rs2_idx)) rd2 = rf[rs2_idx[AW-1:0]];
    if (BYPASS && wb_wr_en && wb_wr_addr == rs1_idx && live(rs1_idx))
      rd1 = wb_wr_data;
    if (BYPASS && wb_wr_en && wb_wr_addr == rs2_idx && live(rs2_idx))
      rd2 = wb_wr_data;
  end

  always_comb begin
    d             = '0;
    d.pc          = in_pc;
    d.rs1_data    = rd1;
    d.rs2_data    = rd2;
    d.imm         = imm;
    d.rs1         = rs1_idx;
    d.rs2         = rs2_idx;
    d.funct3      = f3;
    d.alu_ctrl    = alu;
    d.alu_src_imm = src_imm;
    d.alu_src_pc  = src_pc;
    d.wr_en       = ud && !ill;
    d.rd          = (ud && !ill) ? rd_idx : 5'd0;
    d.mem_read    = mrd && !ill;
    d.mem_write   = mwr && !ill;
    d.branch      = br;
    d.jump        = jmp;
    d.illegal     = ill;
  end

  always_ff @(posedge clk) begin
    if (rst && RESET_REGFILE) begin
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
    end else if (wb_wr_en && live(wb_wr_addr)) begin
      rf[wb_wr_addr[AW-1:0]] <= wb_wr_data;
    end
  end

  assign in_ready = !vld || out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= 1'b0;
      q   <= '0;
    end else if (flush) begin
      vld <= 1'b0;
    end else if (in_valid && in_ready) begin
      vld <= 1'b1;
      q   <= d;
    end else if (out_ready) begin
      vld <= 1'b0;
    end else if (vld && wb_wr_en) begin
      // Keep a stalled bundle's operands in step with retiring writes.
      if (live(q.rs1) && wb_wr_addr == q.rs1) q.rs1_data <= wb_wr_data;
      if (live(q.rs2) && wb_wr_addr == q.rs2) q.rs2_data <= wb_wr_data;
    end
  end

  assign out_valid       = vld;
  assign out_pc          = q.pc;
  assign out_rs1_data    = q.rs1_data;
  assign out_rs2_data    = q.rs2_data;
  assign out_rs1         = q.rs1;
  assign out_rs2         = q.rs2;
  assign out_rd          = q.rd;
  assign out_funct3      = q.funct3;
  assign out_alu_ctrl    = q.alu_ctrl;
  assign out_imm         = q.imm;
  assign out_alu_src_imm = q.alu_src_imm;
  assign out_alu_src_pc  = q.alu_src_pc;
  assign out_wr_en       = q.wr_en;
  assign out_mem_read    = q.mem_read;
  assign out_mem_write   = q.mem_write;
  assign out_branch      = q.branch;
  assign out_jump        = q.jump;
  assign out_illegal     = q.illegal;

endmodule

// File: tb/tb_rv_decode_unit.sv
// tb_rv_decode_unit: scoreboard bench for rv_decode_unit, two configurations
// (RV32I with bypass, RV32E without) driven by identical stimulus.
module tb_rv_decode_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_instr = '0;
  logic [31:0] in_pc = '0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b1;
  logic        wb_wr_en = 1'b0;
  logic [4:0]  wb_wr_addr = '0;
  logic [31:0] wb_wr_data = '0;

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [3:0]  alu;
    logic        src_imm;
    logic        src_pc;
    logic        wr;
    logic        mrd;
    logic        mwr;
    logic        br;
    logic        jmp;
    logic        ill;
  } exp_t;

  typedef struct packed {
    exp_t a;
    exp_t b;
  } pair_t;

  logic a_in_ready, a_out_valid, b_in_ready, b_out_valid;
  logic [31:0] a_out_pc, a_out_rs1_data, a_out_rs2_data, a_out_imm;
  logic [31:0] b_out_pc, b_out_rs1_data, b_out_rs2_data, b_out_imm;
  logic [4:0]  a_out_rs1, a_out_rs2, a_out_rd, b_out_rs1, b_out_rs2, b_out_rd;
  logic [2:0]  a_out_funct3, b_out_funct3;
  logic [3:0]  a_out_alu_ctrl, b_out_alu_ctrl;
  logic a_out_alu_src_imm, a_out_alu_src_pc, a_out_wr_en, a_out_mem_read;
  logic a_out_mem_write, a_out_branch, a_out_jump, a_out_illegal;
  logic b_out_alu_src_imm, b_out_alu_src_pc, b_out_wr_en, b_out_mem_read;
  logic b_out_mem_write, b_out_branch, b_out_jump, b_out_illegal;

  rv_decode_unit #(.NREGS(32), .BYPASS(1'b1), .RESET_REGFILE(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_pc(a_out_pc),
    .out_rs1_data(a_out_rs1_data), .out_rs2_data(a_out_rs2_data),
    .out_rs1(a_out_rs1), .out_rs2(a_out_rs2), .out_rd(a_out_rd),
    .out_funct3(a_out_funct3), .out_alu_ctrl(a_out_alu_ctrl),
    .out_imm(a_out_imm), .out_alu_src_imm(a_out_alu_src_imm),
    .out_alu_src_pc(a_out_alu_src_pc), .out_wr_en(a_out_wr_en),
    .out_mem_read(a_out_mem_read), .out_mem_write(a_out_mem_write),
    .out_branch(a_out_branch), .out_jump(a_out_jump),
    .out_illegal(a_out_illegal), .wb_wr_en(wb_wr_en),
    .wb_wr_addr(wb_wr_addr), .wb_wr_data(wb_wr_data)
  );

  rv_decode_unit #(.NREGS(16), .BYPASS(1'b0), .RESET_REGFILE(1'b1)) dut_e (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_pc(b_out_pc),
    .out_rs1_data(b_out_rs1_data), .out_rs2_data(b_out_rs2_data),
    .out_rs1(b_out_rs1), .out_rs2(b_out_rs2), .out_rd(b_out_rd),
    .out_funct3(b_out_funct3), .out_alu_ctrl(b_out_alu_ctrl),
    .out_imm(b_out_imm), .out_alu_src_imm(b_out_alu_src_imm),
    .out_alu_src_pc(b_out_alu_src_pc), .out_wr_en(b_out_wr_en),
    .out_mem_read(b_out_mem_read), .out_mem_write(b_out_mem_write),
    .out_branch(b_out_branch), .out_jump(b_out_jump),
    .out_illegal(b_out_illegal), .wb_wr_en(wb_wr_en),
    .wb_wr_addr(wb_wr_addr), .wb_wr_data(wb_wr_data)
  );

  exp_t act_a, act_b;
  assign act_a = {a_out_pc, a_out_rs1_data, a_out_rs2_data, a_out_imm,
                  a_out_rs1, a_out_rs2, a_out_rd, a_out_funct3,
                  a_out_alu_ctrl, a_out_alu_src_imm, a_out_alu_src_pc,
                  a_out_wr_en, a_out_mem_read, a_out_mem_write,
                  a_out_branch, a_out_jump, a_out_illegal};
  assign act_b = {b_out_pc, b_out_rs1_data, b_out_rs2_data, b_out_imm,
                  b_out_rs1, b_out_rs2, b_out_rd, b_out_funct3,
                  b_out_alu_ctrl, b_out_alu_src_imm, b_out_alu_src_pc,
                  b_out_wr_en, b_out_mem_read, b_out_mem_write,
                  b_out_branch, b_out_jump, b_out_illegal};

  int n_tests = 0;
  int n_fail  = 0;
  pair_t sbq[$];
  logic [31:0] rfa [32];
  logic [31:0] rfb [32];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chkb(input string nm, input exp_t act, input exp_t exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] readv(input logic [4:0] idx, input int nregs,
                                        input bit byp,
                                        input logic [31:0] rf [32]);
    if (idx == 5'd0 || int'(idx) >= nregs) return 32'd0;
    if (byp && wb_wr_en && wb_wr_addr == idx) return wb_wr_data;
    return rf[idx];
  endfunction

  // Reference decode: format table by opcode, immediates built arithmetically.
  function automatic exp_t ref_dec(input logic [31:0] ins, input logic [31:0] pc,
                                   input int nregs, input bit byp,
                                   input logic [31:0] rf [32]);
    exp_t e;
    bit u1, u2, ud;
    logic [4:0] rdf;
    logic [31:0] ii, is_, ib, iu, ij;
    e = '0;
    u1 = 0; u2 = 0; ud = 0;
    ii  = 32'($signed(ins) >>> 20);
    is_ = (ii & ~32'h1F) | {27'd0, ins[11:7]};
    ib  = (is_ & ~32'h801) | (32'(is_[0]) << 11);
    iu  = ins & 32'hFFFFF000;
    ij  = (ii & 32'hFFF007FE) | (ins & 32'h000FF000) | (32'(ii[0]) << 11);
    e.pc = pc;
    e.f3 = ins[14:12];
    case (ins[6:0])
      7'h33: begin u1 = 1; u2 = 1; ud = 1; e.alu = {ins[30], ins[14:12]}; end
      7'h13: begin
        u1 = 1; ud = 1; e.src_imm = 1; e.imm = ii;
        e.alu = {(ins[14:12] == 3'd5) ? ins[30] : 1'b0, ins[14:12]};
      end
      7'h03: begin u1 = 1; ud = 1; e.src_imm = 1; e.imm = ii; e.mrd = 1; end
      7'h67: begin u1 = 1; ud = 1; e.src_imm = 1; e.imm = ii; e.jmp = 1; end
      7'h23: begin u1 = 1; u2 = 1; e.src_imm = 1; e.imm = is_; e.mwr = 1; end
      7'h63: begin u1 = 1; u2 = 1; e.imm = ib; e.br = 1; e.alu = 4'd8; end
      7'h37: begin ud = 1; e.src_imm = 1; e.imm = iu; end
      7'h17: begin ud = 1; e.src_imm = 1; e.src_pc = 1; e.imm = iu; end
      7'h6F: begin
        ud = 1; e.src_imm = 1; e.src_pc = 1; e.imm = ij; e.jmp = 1;
      end
      default: e.ill = 1;
    endcase
    e.rs1 = u1 ? ins[19:15] : 5'd0;
    e.rs2 = u2 ? ins[24:20] : 5'd0;
    rdf   = ud ? ins[11:7] : 5'd0;
    if (int'(e.rs1) >= nregs || int'(e.rs2) >= nregs || int'(rdf) >= nregs)
      e.ill = 1;
    if (e.ill) begin e.mrd = 0; e.mwr = 0; end
    e.wr = ud && !e.ill;
    e.rd = e.wr ? rdf : 5'd0;
    e.rs1_data = readv(e.rs1, nregs, byp, rf);
    e.rs2_data = readv(e.rs2, nregs, byp, rf);
    return e;
  endfunction

  function automatic exp_t hold_upd(input exp_t e, input int nregs);
    if (e.rs1 != 0 && int'(e.rs1) < nregs && wb_wr_addr == e.rs1)
      e.rs1_data = wb_wr_data;
    if (e.rs2 != 0 && int'(e.rs2) < nregs && wb_wr_addr == e.rs2)
      e.rs2_data = wb_wr_data;
    return e;
  endfunction

  // One clock: apply this cycle's inputs to the model at the edge.
  task automatic cyc();
    pair_t p;
    bit held;
    @(posedge clk);
    held = sbq.size() > 0;
    if (rst) begin
      sbq.delete();
      for (int i = 0; i < 32; i++) begin rfa[i] = '0; rfb[i] = '0; end
    end else begin
      if (flush) begin
        sbq.delete();
      end else if (in_valid && (!held || out_ready)) begin
        p.a = ref_dec(in_instr, in_pc, 32, 1'b1, rfa);
        p.b = ref_dec(in_instr, in_pc, 16, 1'b0, rfb);
        sbq.delete();
        sbq.push_back(p);
      end else if (held && !out_ready && wb_wr_en) begin
        p = sbq[0];
        p.a = hold_upd(p.a, 32);
        p.b = hold_upd(p.b, 16);
        sbq[0] = p;
      end
      if (wb_wr_en && wb_wr_addr != 0) begin
        rfa[wb_wr_addr] = wb_wr_data;
        if (wb_wr_addr < 5'd16) rfb[wb_wr_addr] = wb_wr_data;
      end
    end
    #1;
  endtask

  task automatic issue(input logic [31:0] ins, input logic [31:0] pc);
    in_valid = 1'b1;
    in_instr = ins;
    in_pc    = pc;
    cyc();
    in_valid = 1'b0;
  endtask

  task automatic wb(input logic [4:0] a, input logic [31:0] v);
    wb_wr_en   = 1'b1;
    wb_wr_addr = a;
    wb_wr_data = v;
    cyc();
    wb_wr_en   = 1'b0;
  endtask

  always @(negedge clk) begin
    logic ev;
    ev = sbq.size() > 0;
    chk("handshake", {28'd0, a_out_valid, b_out_valid, a_in_ready, b_in_ready},
        {28'd0, ev, ev, !ev || out_ready, !ev || out_ready});
    if (ev) begin
      if (a_out_valid) chkb("bundle_rv32i", act_a, sbq[0].a);
      if (b_out_valid) chkb("bundle_rv32e", act_b, sbq[0].b);
      if (out_ready) void'(sbq.pop_front());
    end
  end

  function automatic logic [31:0] rnd_instr();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 10))
      0: r[6:0] = 7'h33;
      1: r[6:0] = 7'h13;
      2: r[6:0] = 7'h03;
      3: r[6:0] = 7'h67;
      4: r[6:0] = 7'h23;
      5: r[6:0] = 7'h63;
      6: r[6:0] = 7'h37;
      7: r[6:0] = 7'h17;
      8: r[6:0] = 7'h6F;
      default: ;
    endcase
    return r;
  endfunction

  initial begin
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    chk("reset_valid", {30'd0, a_out_valid, b_out_valid}, 32'd0);
    chk("reset_in_ready", {30'd0, a_in_ready, b_in_ready}, 32'd3);

    wb(5'd5, 32'h1234);
    issue(32'h000280B3, 32'h100);
    chk("add_latency_valid", 32'(a_out_valid), 32'd1);
    chk("add_rs1_data", a_out_rs1_data, 32'h1234);
    chk("add_alu", 32'(a_out_alu_ctrl), 32'h0);
    chk("add_wr_rd", {26'd0, a_out_wr_en, a_out_rd}, {26'd0, 1'b1, 5'd1});

    issue(32'h402081B3, 32'h104);
    chk("sub_alu", 32'(a_out_alu_ctrl), 32'h8);
    issue(32'h40325213, 32'h108);
    chk("srai_alu", 32'(a_out_alu_ctrl), 32'hD);
    issue(32'hFE20AE23, 32'h10C);
    chk("sw_imm", a_out_imm, 32'hFFFFFFFC);
    chk("sw_mem_write", 32'(a_out_mem_write), 32'd1);
    issue(32'hFE208CE3, 32'h110);
    chk("beq_imm", a_out_imm, 32'hFFFFFFF8);
    chk("beq_branch", 32'(a_out_branch), 32'd1);
    issue(32'h001000EF, 32'h114);
    chk("jal_imm", a_out_imm, 32'h00000800);
    chk("jal_jump_pc", {30'd0, a_out_jump, a_out_alu_src_pc}, 32'd3);

    issue(32'h00038433, 32'h200);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'h000280B3;
    in_pc     = 32'h204;
    cyc();
    chk("stall_in_ready", {30'd0, a_in_ready, b_in_ready}, 32'd0);
    wb(5'd7, 32'hAA);
    chk("hold_rs1_a", a_out_rs1_data, 32'hAA);
    chk("hold_rs1_b", b_out_rs1_data, 32'hAA);
    wb(5'd0, 32'hFFFF);
    chk("hold_x0_rs2", a_out_rs2_data, 32'd0);
    chk("hold_x0_rs1", a_out_rs1_data, 32'hAA);
    out_ready = 1'b1;
    cyc();
    in_valid = 1'b0;
    cyc();

    wb(5'd9, 32'h11);
    wb_wr_en   = 1'b1;
    wb_wr_addr = 5'd9;
    wb_wr_data = 32'h55;
    issue(32'h00048533, 32'h300);
    wb_wr_en = 1'b0;
    chk("bypass_on", a_out_rs1_data, 32'h55);
    chk("bypass_off", b_out_rs1_data, 32'h11);

    issue(32'h0000007F, 32'h400);
    chk("ill_opcode", {29'd0, a_out_illegal, a_out_wr_en, a_out_valid}, 32'd5);
    issue(32'h00100A10, 32'h404);
    chk("ill_lowbits", 32'(a_out_illegal), 32'd1);
    issue(32'h00100A13, 32'h408);
    chk("addi_x20_rv32i", {30'd0, a_out_illegal, a_out_wr_en}, 32'd1);
    chk("addi_x20_rv32e", {29'd0, b_out_illegal, b_out_wr_en, b_out_valid},
        32'd5);

    issue(32'h000280B3, 32'h500);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'h402081B3;
    flush     = 1'b1;
    cyc();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_valid", {30'd0, a_out_valid, b_out_valid}, 32'd0);
    cyc();
    chk("flush_dropped", {30'd0, a_out_valid, b_out_valid}, 32'd0);
    out_ready = 1'b1;

    issue(32'h00038433, 32'h600);
    out_ready = 1'b0;
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chkb("rst_stall_bundle", act_a, '0);
    chk("rst_stall_valid", {30'd0, a_out_valid, a_in_ready}, 32'd1);
    out_ready = 1'b1;
    issue(32'h000280B3, 32'h700);
    chk("rf_cleared", a_out_rs1_data, 32'd0);

    for (int i = 0; i < 3000; i++) begin
      in_valid   = ($urandom % 4) != 0;
      in_instr   = rnd_instr();
      in_pc      = $urandom & 32'hFFFFFFFC;
      out_ready  = ($urandom % 10) < 7;
      flush      = ($urandom % 25) == 0;
      wb_wr_en   = $urandom % 2 == 1;
      wb_wr_addr = ($urandom % 3 == 0) ? in_instr[19:15] : 5'($urandom);
      wb_wr_data = $urandom;
      rst        = ($urandom % 300) == 0;
      cyc();
    end

    in_valid  = 1'b0;
    flush     = 1'b0;
    rst       = 1'b0;
    wb_wr_en  = 1'b0;
    out_ready = 1'b1;
    repeat (3) cyc();
    chk("drain_empty", 32'(sbq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
